// File: rtl/iccm_loader.sv
// Boot loader: assembles a little-endian byte stream into ICCM words and holds the core in reset until done.
// Optional trailing checksum enabled by defining ICCM_LOADER_CHECKSUM_EN.
module iccm_loader #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 iccm_write,
  output logic [AddrWidth-1:0] iccm_address,
  output logic [DataWidth-1:0] iccm_data,
  output logic                 core_rst,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int IdxWidth = AddrWidth - 2;
  localparam logic [DataWidth-1:0] MaxWords = DataWidth'(1) << IdxWidth;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_FIN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
`ifdef ICCM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [DataWidth-1:0]  word_q, word_d;
  logic [IdxWidth-1:0]   index_q, index_d;
  logic [IdxWidth-1:0]   last_idx_q, last_idx_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  wr_q, wr_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef ICCM_LOADER_CHECKSUM_EN
  logic [DataWidth-1:0]  sum_q, sum_d;
`endif

  logic                  accept;
  logic                  word_end;
  logic [DataWidth-1:0]  full_word;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    word_d     = word_q;
    index_d    = index_q;
    last_idx_d = last_idx_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef ICCM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    accept    = rx_valid && rx_ready_q;
    word_end  = accept && (lane_q == 2'd3);
    // Bytes shift in from the top so the first byte of a word ends in [7:0].
    full_word = {rx_byte, word_q[DataWidth-1:8]};

    if (accept) begin
      lane_d = lane_q + 2'd1;
      word_d = full_word;
    end

    case (state_q)
      S_HDR: begin
`ifdef ICCM_LOADER_CHECKSUM_EN
        sum_d = '0;
`endif
        if (word_end) begin
          if (full_word == '0) begin
            state_d = S_DONE;
          end else if (full_word > MaxWords) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            index_d    = '0;
            last_idx_d = IdxWidth'(full_word - DataWidth'(1));
          end
        end
      end
      S_DATA: begin
        if (word_end) begin
          wr_d   = 1'b1;
          addr_d = {index_q, 2'b00};
          data_d = full_word;
`ifdef ICCM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + full_word;
`endif
          if (index_q == last_idx_q) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FIN;
`endif
          end else begin
            index_d = index_q + IdxWidth'(1);
          end
        end
      end
`ifdef ICCM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (word_end) begin
          state_d = (full_word == sum_q) ? S_FIN : S_ERR;
        end
      end
`endif
      S_FIN:   state_d = S_DONE;
      default: ;
    endcase

    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef ICCM_LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    // Error flags with the deciding byte; done trails DONE by one edge.
    err_d      = (state_d == S_ERR);
    done_d     = (state_q == S_DONE);
    core_rst_d = (state_q != S_DONE);
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_q    <= S_HDR;
      lane_q     <= '0;
      word_q     <= '0;
      index_q    <= '0;
      last_idx_q <= '0;
      rx_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ICCM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      index_q    <= index_d;
      last_idx_q <= last_idx_d;
      rx_ready_q <= rx_ready_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ICCM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign iccm_write   = wr_q;
  assign iccm_address = addr_q;
  assign iccm_data    = data_q;
  assign core_rst     = core_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Randomized bench for iccm_loader: a stream-level model predicts every write, flag and ready cycle.
module tb_iccm_loader;

`ifdef ICCM_LOADER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif
  localparam int MaxWords = 8192;

  logic        brq_clk = 1'b0;
  logic        brq_rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        iccm_write;
  logic [14:0] iccm_address;
  logic [31:0] iccm_data;
  logic        core_rst;
  logic        load_done;
  logic        load_error;

  iccm_loader #(.DataWidth(32), .AddrWidth(15)) dut (
    .brq_clk      (brq_clk),
    .brq_rst      (brq_rst),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .iccm_write   (iccm_write),
    .iccm_address (iccm_address),
    .iccm_data    (iccm_data),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  always #5 brq_clk = ~brq_clk;

  typedef struct {
    int          edge_n;
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;

  // Model of the current image and its progress.
  logic [7:0]  stream[$];
  logic [31:0] img_words[$];
  int          img_n;
  logic [31:0] img_csum;
  int          limit = 0;
  int          consumed = 0;
  bit          ready_ok = 1'b0;
  int          done_edge = -1;
  int          err_edge = -1;
  wr_t         exp_q[$];
  wr_t         log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic logic [31:0] word_sum(input int n);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < n; i++) s = s + img_words[i];
    return s;
  endfunction

  task automatic load_image(input int n, input logic [31:0] csum);
    logic [31:0] cnt;
    cnt = 32'(n);
    img_n = n;
    img_csum = csum;
    stream.delete();
    for (int k = 0; k < 4; k++) stream.push_back(cnt[8*k +: 8]);
    if (n == 0 || n > MaxWords) begin
      limit = 4;
      for (int k = 0; k < 8; k++) stream.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) stream.push_back(img_words[i][8*k +: 8]);
      if (CsumEn)
        for (int k = 0; k < 4; k++) stream.push_back(csum[8*k +: 8]);
      limit = 4 + 4 * n + (CsumEn ? 4 : 0);
    end
  endtask

  // Byte p of the stream is consumed on edge e: record what must follow.
  task automatic model_consume(input int p, input int e);
    if (p == 3) begin
      if (img_n == 0) done_edge = e + 1;
      else if (img_n > MaxWords) err_edge = e;
    end else if (p >= 4 && p < 4 + 4 * img_n && ((p - 4) % 4) == 3) begin
      wr_t w;
      int  i;
      i = (p - 4) / 4;
      w.edge_n = e;
      w.addr = 15'(4 * i);
      w.data = img_words[i];
      exp_q.push_back(w);
      if (i == img_n - 1 && !CsumEn) done_edge = e + 2;
    end else if (CsumEn && p == 4 + 4 * img_n + 3) begin
      if (img_csum == word_sum(img_n)) done_edge = e + 2;
      else err_edge = e;
    end
  endtask

  task automatic check_outputs();
    bit exp_done;
    bit exp_err;
    chk("rx_ready", 32'(rx_ready), 32'(ready_ok && consumed < limit));
    if (exp_q.size() > 0 && exp_q[0].edge_n == edges) begin
      wr_t w;
      w = exp_q.pop_front();
      chk("iccm_write", 32'(iccm_write), 32'd1);
      chk("iccm_address", 32'(iccm_address), 32'(w.addr));
      chk("iccm_data", iccm_data, w.data);
    end else begin
      chk("iccm_write_idle", 32'(iccm_write), 32'd0);
    end
    exp_done = (done_edge >= 0) && (edges >= done_edge);
    exp_err  = (err_edge >= 0) && (edges >= err_edge);
    chk("load_done", 32'(load_done), 32'(exp_done));
    chk("core_rst", 32'(core_rst), 32'(!exp_done));
    chk("load_error", 32'(load_error), 32'(exp_err));
    if (iccm_write) begin
      wr_t l;
      l.edge_n = edges;
      l.addr = iccm_address;
      l.data = iccm_data;
      log_q.push_back(l);
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] b, input bit r);
    int e;
    rx_valid = v;
    rx_byte  = b;
    brq_rst  = r;
    e = edges + 1;
    if (r) begin
      consumed = 0;
      exp_q.delete();
      done_edge = -1;
      err_edge = -1;
      ready_ok = 1'b0;
    end else begin
      if (v && ready_ok && consumed < limit) begin
        model_consume(consumed, e);
        consumed++;
      end
      ready_ok = 1'b1;
    end
    @(negedge brq_clk);
    edges++;
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    chk("rst_address", 32'(iccm_address), 32'd0);
    chk("rst_data", iccm_data, 32'd0);
    log_q.delete();
  endtask

  task automatic run(input int gap_pct, input int stop_after, input int idle);
    int guard = 0;
    while (consumed < stop_after && guard < 4000) begin
      bit v;
      v = ($urandom_range(99) >= gap_pct) && (consumed < stream.size());
      cycle(v, v ? stream[consumed] : 8'h00, 1'b0);
      guard++;
    end
    if (guard >= 4000) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: consumed %0d, required %0d", consumed, stop_after);
    end
    // Junk presented after the image must never be taken.
    repeat (idle) cycle(1'b1, 8'($urandom), 1'b0);
  endtask

  task automatic random_image(input int n, input bit bad_csum);
    img_words.delete();
    for (int i = 0; i < n; i++) img_words.push_back($urandom);
    load_image(n, word_sum(n) + (bad_csum ? 32'd1 : 32'd0));
  endtask

  initial begin
    // Two-word image at one byte per cycle.
    do_reset();
    img_words = '{32'h0000_0013, 32'hDEAD_BEEF};
    load_image(2, 32'hDEAD_BF02);
    run(0, limit, 6);
    chk("t1_nwrites", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t1_addr0", 32'(log_q[0].addr), 32'h0000);
      chk("t1_data0", log_q[0].data, 32'h0000_0013);
      chk("t1_addr1", 32'(log_q[1].addr), 32'h0004);
      chk("t1_data1", log_q[1].data, 32'hDEAD_BEEF);
      chk("t1_spacing", 32'(log_q[1].edge_n - log_q[0].edge_n), 32'd4);
    end
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_core_rst", 32'(core_rst), 32'd0);
    chk("t1_ready", 32'(rx_ready), 32'd0);

    // Empty image.
    do_reset();
    img_words.delete();
    load_image(0, 32'h0);
    run(0, limit, 4);
    chk("t2_nwrites", 32'(log_q.size()), 32'd0);
    chk("t2_done", 32'(load_done), 32'd1);

    // Oversize count.
    do_reset();
    load_image(32'h2001, 32'h0);
    run(0, limit, 4);
    chk("t3_nwrites", 32'(log_q.size()), 32'd0);
    chk("t3_error", 32'(load_error), 32'd1);
    chk("t3_core_rst", 32'(core_rst), 32'd1);
    chk("t3_ready", 32'(rx_ready), 32'd0);

    // Three words, gap-free then with random valid gaps.
    do_reset();
    random_image(3, 1'b0);
    run(0, limit, 4);
    do_reset();
    load_image(3, word_sum(3));
    run(50, limit, 6);
    chk("t4_nwrites", 32'(log_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_q.size(); i++)
      chk("t4_data", log_q[i].data, img_words[i]);

    // Reset after six bytes, then the full image resent.
    do_reset();
    random_image(4, 1'b0);
    run(0, 6, 0);
    do_reset();
    load_image(4, word_sum(4));
    run(0, limit, 6);
    chk("t5_nwrites", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("t5_addr", 32'(log_q[i].addr), 32'(4 * i));
    chk("t5_done", 32'(load_done), 32'd1);

    // Randomized images.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      random_image(int'($urandom_range(6, 1)), CsumEn && ($urandom_range(1) == 1));
      run(int'($urandom_range(60)), limit, 5);
    end

`ifdef ICCM_LOADER_CHECKSUM_EN
    do_reset();
    img_words = '{32'h1234_5678};
    load_image(1, 32'h1234_5678);
    run(0, limit, 5);
    chk("t7_done", 32'(load_done), 32'd1);
    do_reset();
    load_image(1, 32'h1234_5679);
    run(0, limit, 5);
    chk("t7_error", 32'(load_error), 32'd1);
    chk("t7_core_rst", 32'(core_rst), 32'd1);
    chk("t7_nwrites", 32'(log_q.size()), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iccm_loader.md
# iccm_loader

Boot-time instruction loader and write-side master for the ICCM write port (`i_write`/`i_data`/`address`), which the core never drives; the core only reads the ICCM. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into consecutive ICCM word addresses and holds the core in reset until the image is complete. It sits beside the core at top level, between the external byte source (UART RX or debug link) and the ICCM.

## Interface
Parameters:
- `DataWidth`, 32, ICCM word width; fixed at 32 for this block.
- `AddrWidth`, 15, ICCM byte-address width; capacity is 2^(AddrWidth-2) words.

Ports:
- `brq_clk`  in  1  sole clock, rising edge.
- `brq_rst`  in  1  reset; synchronous and active-high.
- `rx_byte`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_byte` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `iccm_write`  out  1  one-cycle ICCM write strobe (drives ICCM `i_write`).
- `iccm_address`  out  AddrWidth  ICCM byte address; always word-aligned, bits [1:0] = 0.
- `iccm_data`  out  DataWidth  word to write (drives ICCM `i_data`).
- `core_rst`  out  1  reset to the core; high until the load completes.
- `load_done`  out  1  image written successfully; sticky until `brq_rst`.
- `load_error`  out  1  load aborted; sticky until `brq_rst`.

## Operation
- Stream format:
  - 4-byte word count N (little-endian).
  - N data words, 4 bytes each, little-endian; first byte lands in bits [7:0].
  - Optional 4-byte checksum (see Configuration).
- States:
  - HDR collects 4 count bytes. Then N=0 goes to DONE, N>2^(AddrWidth-2) goes to ERR, else DATA.
  - DATA collects words. Each completed word is written, then the word index increments.
  - After word N: go to CSUM if the macro is defined, else FIN.
  - CSUM collects 4 bytes, then goes to FIN on match or ERR on mismatch.
  - FIN lasts one cycle and waits for the last write to retire, then goes to DONE.
  - DONE and ERR are terminal.
- `rx_ready` = 1 in HDR, DATA and CSUM; 0 in FIN, DONE, ERR and during the reset cycle.
- A byte is consumed only on an edge where `rx_valid && rx_ready`. `rx_valid` with `rx_ready`=0 is ignored, and the byte is not buffered.
- Byte-lane counter: 2 bits, wraps 3→0. A word is complete when lane 3 is consumed.
- Write address = 4 × word index. Index width is AddrWidth-2; it never wraps because the length check precludes overflow.
- `core_rst` = 1 in every state except DONE. ERR keeps the core held in reset.
- `iccm_write`, `iccm_address` and `iccm_data` are registered.
- Reset values:
  - `rx_ready`=0, `iccm_write`=0, `iccm_address`=0, `iccm_data`=0.
  - `core_rst`=1, `load_done`=0, `load_error`=0.
  - State=HDR; lane, index and checksum counters all 0.
- Reset mid-load: returns to HDR, discards any partial word, and reasserts `core_rst`. ICCM contents are not cleared. A reset asserted in the same cycle as a write strobe wins; the strobe is dropped.
- After reset in DONE, the core is held again and a fresh image is expected.

## Timing
- Byte-to-write latency: the edge consuming lane 3 of word i sets `iccm_write`=1, `iccm_address`=4i and `iccm_data`=word for exactly the following cycle. The strobe is never asserted for two consecutive cycles on the same address.
- Back-to-back input at one byte per cycle yields one write every 4 cycles. Throughput is 1 byte/cycle with no stalls.
- The edge after the final write cycle enters DONE. The next edge drives `load_done`=1 and `core_rst`=0 together.
- Checksum and oversize errors: `load_error`=1 and `rx_ready`=0 on the edge after the deciding byte. No write is issued for a rejected image's remainder.

## Configuration
- `ICCM_LOADER_CHECKSUM_EN` defined:
  - The loader keeps a running 32-bit sum mod 2^32 of all data words, cleared in HDR.
  - It expects a trailing 4-byte little-endian checksum after the data words.
  - Mismatch goes to ERR (`load_error`=1, `core_rst` stays 1).
  - ICCM writes already performed are not undone.
- Not defined:
  - No checksum state, accumulator or trailing bytes.
  - `load_error` rises only on oversize length.

## Test plan
- Count=2, words 0x00000013 and 0xDEADBEEF, 1 byte/cycle.
  - Response: writes (addr 0x0000, 0x00000013) then (addr 0x0004, 0xDEADBEEF), 4 cycles apart.
  - Then `load_done`=1 and `core_rst`=0, with `rx_ready`=0 after.
- Count=0: no `iccm_write`; `load_done`=1 with no data bytes consumed.
- Count=0x2001 with AddrWidth=15: `load_error`=1, `core_rst` stays 1, no writes, `rx_ready`=0.
- Random gaps on `rx_valid` with count=3: writes identical to the gap-free run. No byte is lost or duplicated.
- `brq_rst` pulsed after 6 bytes of a count=4 image, then the full image resent: exactly 4 writes at 0x0000–0x000C with the correct data, then `load_done`=1.
- Macro on, count=1, word 0x12345678:
  - Checksum 0x12345678 gives `load_done`=1.
  - Checksum 0x12345679 gives `load_error`=1 and `core_rst` stays 1.
